// File: rtl/vec_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_check_pkg
// Description : Shared types and default sizes for the vector equivalence
//               checker (sequencer state encoding, datapath widths).
// Revision    : 1.0 - initial release
// ============================================================================
package vec_check_pkg;

    localparam int DEF_IN_W       = 50;
    localparam int DEF_OUT_W      = 30;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_SETTLE_CYC = 1;

    // Sequencer states; one vector walks FETCH -> LOAD -> SETTLE -> CHECK.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vec_check_ctrl_fail_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fail_tracker
// Description : Mismatch statistics for the equivalence run: saturating
//               mismatch counter plus capture of the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module fail_tracker
    import vec_check_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              chk_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [OUT_W-1:0]  ref_out,
    input  logic [OUT_W-1:0]  opt_out,
    output logic [ADDR_W:0]   mismatch_cnt,
    output logic              any_fail,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0]  first_fail_diff
);

    localparam logic [ADDR_W:0] CNT_MAX = '1;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [OUT_W-1:0] diff;
    logic             miss;

    assign diff = ref_out ^ opt_out;
    assign miss = chk_en && (diff != '0);

    // Count mismatches (saturating) and latch the first one of the run.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mismatch_cnt    <= '0;
            any_fail        <= 1'b0;
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
        end else if (miss) begin
            if (mismatch_cnt != CNT_MAX) begin
                mismatch_cnt <= mismatch_cnt + CNT_ONE;
            end
            if (!any_fail) begin
                first_fail_idx  <= idx;
                first_fail_diff <= diff;
            end
            any_fail <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vec_check_ctrl
// Description : Self-timed sequencer that streams test vectors from memory
//               into two dut instances, compares their outputs, writes the
//               optimized output back and keeps mismatch statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_check_ctrl
    import vec_check_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_vec,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IN_W-1:0]   mem_rdata,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  ref_out,
    input  logic [OUT_W-1:0]  opt_out,
    output logic              res_wr_en,
    output logic [OUT_W-1:0]  res_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   mismatch_cnt,
    output logic              any_fail,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0]  first_fail_diff
);

    localparam int               SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETTLE_CYC - 1);
    localparam logic [SET_W-1:0] SET_ONE   = SET_W'(1);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic [ADDR_W:0]   run_len;
    logic [ADDR_W:0]   num_clamped;
    logic [SET_W-1:0]  settle_cnt;
    logic              last_vec;
    logic              clr;
    logic              chk_en;

    // Requests beyond the memory size run over the whole memory.
    assign num_clamped = (num_vec > DEPTH_CNT) ? DEPTH_CNT : num_vec;
    assign idx_next    = idx + IDX_ONE;
    assign last_vec    = (({1'b0, idx} + LEN_ONE) == run_len);
    assign clr         = (state == ST_IDLE) && start;
    assign chk_en      = (state == ST_CHECK);

    // Sequencer: memory strobes are visible in the cycle of their state;
    // busy/done update when DONE is left so an empty run shows one busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            run_len    <= '0;
            settle_cnt <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            dut_in     <= '0;
            res_wr_en  <= 1'b0;
            res_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            res_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        idx     <= '0;
                        run_len <= num_clamped;
                        if (num_clamped == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_FETCH;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= abort ? ST_DONE : ST_LOAD;
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_DONE;
                    end else begin
                        dut_in     <= mem_rdata;
                        settle_cnt <= SET_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_DONE;
                    end else if (settle_cnt == '0) begin
                        state     <= ST_CHECK;
                        res_wr_en <= 1'b1;
                        mem_addr  <= idx;
                        res_wdata <= opt_out;
                    end else begin
                        settle_cnt <= settle_cnt - SET_ONE;
                    end
                end
                ST_CHECK: begin
                    if (abort || last_vec) begin
                        state <= ST_DONE;
                    end else begin
                        idx       <= idx_next;
                        mem_addr  <= idx_next;
                        mem_rd_en <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fail_tracker #(
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_fail_tracker (
        .clk             (clk),
        .rst             (rst),
        .clr             (clr),
        .chk_en          (chk_en),
        .idx             (idx),
        .ref_out         (ref_out),
        .opt_out         (opt_out),
        .mismatch_cnt    (mismatch_cnt),
        .any_fail        (any_fail),
        .first_fail_idx  (first_fail_idx),
        .first_fail_diff (first_fail_diff)
    );

endmodule
`default_nettype wire

// File: doc/vec_check_ctrl.md
Name: vec_check_ctrl

Overview:
Sequencer that drives the 50-in/30-out combinational dut datapath from a test-vector memory. Each vector is presented to two dut instances, original and instruction-reduced. The block compares their outputs, writes results back and keeps mismatch statistics. It replaces the file-driven one-shot testbench flow with a self-timed, start/done controlled equivalence run.

Parameters:
IN_W, 50, dut input width
OUT_W, 30, dut output width
DEPTH, 1024, vector/result memory depth
ADDR_W, $clog2(DEPTH), memory address width
SETTLE_CYC, 1, cycles dut_in is held before outputs are sampled (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  terminate run early
num_vec  in  ADDR_W+1  vector count for the run, 0..DEPTH
mem_rd_en  out  1  vector memory read strobe
mem_addr  out  ADDR_W  vector/result address
mem_rdata  in  IN_W  vector data, valid 1 cycle after mem_rd_en
dut_in  out  IN_W  registered stimulus to both dut instances
ref_out  in  OUT_W  original dut output
opt_out  in  OUT_W  optimized dut output
res_wr_en  out  1  result memory write strobe
res_wdata  out  OUT_W  captured opt_out
busy  out  1  run in progress
done  out  1  run finished; held until next accepted start
mismatch_cnt  out  ADDR_W+1  number of vectors with ref_out != opt_out
any_fail  out  1  mismatch_cnt != 0
first_fail_idx  out  ADDR_W  index of first mismatching vector
first_fail_diff  out  OUT_W  ref_out ^ opt_out at first mismatch

Behaviour:
- Reset: state IDLE; every output 0, including dut_in, counters and done.
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, FETCH, LOAD, SETTLE, CHECK, DONE.
- IDLE, start=1:
  - Clear mismatch_cnt, any_fail, first_fail_*, done.
  - Set idx=0 and busy=1.
  - If num_vec==0, go to DONE; otherwise go to FETCH.
- FETCH: mem_rd_en=1, mem_addr=idx; go to LOAD.
- LOAD: dut_in<=mem_rdata; load settle counter with SETTLE_CYC-1; go to SETTLE.
- SETTLE: decrement the settle counter; at 0, go to CHECK.
- CHECK:
  - res_wr_en=1, mem_addr=idx, res_wdata=opt_out.
  - On mismatch, increment mismatch_cnt, saturating at 2^(ADDR_W+1)-1.
  - On the first mismatch only, latch idx and the XOR into first_fail_*.
  - If idx==num_vec-1, go to DONE; otherwise idx++ and go to FETCH.
- DONE: busy=0, done=1; go to IDLE next cycle. done stays high.
- Per-vector cost is 3+SETTLE_CYC cycles. done rises 1+N*(3+SETTLE_CYC) cycles after the edge that samples start.
- dut_in holds its last vector after the run ends.
- start while busy: ignored.
- start and abort both high in IDLE: start wins; abort has no effect in IDLE or DONE.
- abort in FETCH/LOAD/SETTLE/CHECK:
  - Next state is DONE.
  - A CHECK in the same cycle still completes its write and compare.
  - Statistics are kept.
- num_vec > DEPTH: clamped to DEPTH at start.
- rst mid-run: immediate return to the reset state; no further memory strobes.
- mem_rd_en and res_wr_en are never high in the same cycle.

Decomposition:
- Package vec_check_pkg holds:
  - state enum (6 states, 3 bits);
  - default IN_W/OUT_W/DEPTH localparams.
- Sub-module fail_tracker holds mismatch_cnt saturation and first-fail latching.
  - Inputs: clr, chk_en, idx, ref_out, opt_out.

Test Plan:
- num_vec=3, identical ref/opt, SETTLE_CYC=1 -> three res_wr_en pulses at addrs 0,1,2; done at cycle 13; mismatch_cnt=0; any_fail=0.
- num_vec=4, opt_out bit 3 flipped on vectors 1 and 3 -> mismatch_cnt=2, first_fail_idx=1, first_fail_diff=30'h8.
- num_vec=0 -> busy for 1 cycle, done at cycle 1, no memory strobes.
- num_vec=8, abort asserted in SETTLE of vector 2 -> done; res_wr_en count=2; idx write 2 absent.
- start pulsed while busy, then rst asserted mid-run -> second start ignored; after rst all outputs 0 and a fresh start runs normally.
- SETTLE_CYC=3, num_vec=2 -> dut_in stable for 3 cycles before each CHECK; done at cycle 13.
